// File: rtl/sw_inport.sv
// Debounced switch input port: committed value on in_port0, read-to-clear change flag and
// wrapping change counter on in_port1. Define SW_INPORT_IRQ_EN to drive irq from the change flag.
module sw_inport #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw,
   input  logic             rd_status,
   output logic [31:0]      in_port0,
   output logic [31:0]      in_port1,
   output logic             irq
);

   typedef enum logic [1:0] {
      StStable,
      StSettling,
      StCommit
   } state_e;

   localparam logic [15:0] CntTerm = 16'(DEBOUNCE_CYCLES - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] cand_q;
   logic [15:0]      cnt_q;
   logic             changed_q;
   logic [7:0]       count_q;
   logic             commit;

   assign commit = (state_q == StCommit);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StStable;
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         changed_q <= 1'b0;
         count_q   <= '0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
         case (state_q)
            StStable: begin
               if (sync2_q != stable_q) begin
                  cand_q  <= sync2_q;
                  cnt_q   <= 16'd1;
                  state_q <= StSettling;
               end
            end
            StSettling: begin
               if (sync2_q != cand_q) begin
                  cand_q <= sync2_q;
                  cnt_q  <= 16'd1;
               end else if (cnt_q == CntTerm) begin
                  // A bounce that settled back on the old value is dropped silently.
                  state_q <= (cand_q == stable_q) ? StStable : StCommit;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StCommit: begin
               stable_q <= cand_q;
               count_q  <= count_q + 8'd1;
               state_q  <= StStable;
            end
            default: state_q <= StStable;
         endcase
         // Set wins over a coincident read so a commit is never lost.
         if (commit) begin
            changed_q <= 1'b1;
         end else if (rd_status) begin
            changed_q <= 1'b0;
         end
      end
   end

   assign in_port0 = 32'(stable_q);
   assign in_port1 = {16'h0000, count_q, 7'b0000000, changed_q};

`ifdef SW_INPORT_IRQ_EN
   logic irq_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else if (commit) begin
         irq_q <= 1'b1;
      end else if (rd_status) begin
         irq_q <= 1'b0;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: doc/sw_inport.md
SW_INPORT -- requirements
Module: sw_inport

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the number of switch inputs.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive equal samples required to commit; legal range 2..65535.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port sw, input, WIDTH bits: raw asynchronous switch levels.
REQ-006 The module SHALL have port rd_status, input, 1 bit: one-cycle strobe from the data memory when the CPU reads in_port1.
REQ-007 The module SHALL have port in_port0, output, 32 bits: {zeros, committed switch value}.
REQ-008 The module SHALL have port in_port1, output, 32 bits: {16'b0, change_count[7:0], 7'b0, changed}.
REQ-009 The module SHALL have port irq, output, 1 bit: change interrupt (see Configuration).

Function
REQ-010 sw SHALL pass through a 2-flop synchronizer; sw_sync is the second-stage value.
REQ-011 The FSM SHALL have exactly three states: STABLE, SETTLING and COMMIT.
REQ-012 STABLE: if sw_sync != stable_val -> load candidate <= sw_sync, cnt <= 1, go SETTLING; else remain.
REQ-013 SETTLING, sw_sync != candidate: candidate <= sw_sync, cnt <= 1, remain in SETTLING.
REQ-014 SETTLING, sw_sync == candidate and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
REQ-015 SETTLING, sw_sync == candidate and cnt == DEBOUNCE_CYCLES-1: go COMMIT.
REQ-016 SETTLING, candidate == stable_val (bounce returned to old value) at terminal count: go STABLE with no commit, flag and count unchanged.
REQ-017 COMMIT, lasting exactly one cycle: stable_val <= candidate, changed <= 1, change_count <= change_count+1 (8-bit, wraps 255->0), go STABLE.
REQ-018 Latency from a clean sw edge to in_port0 update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-019 in_port0 and in_port1 SHALL be registered outputs, valid every cycle, with no read latency.
REQ-020 rd_status SHALL clear changed on the next edge (read-to-clear); change_count is never cleared by reads.
REQ-021 rd_status in the same cycle as COMMIT: changed SHALL remain 1 (set wins), and the read returns pre-commit values.
REQ-022 rd_status while changed==0 SHALL have no effect.
REQ-023 sw change arriving during COMMIT SHALL be detected in the following STABLE cycle per REQ-012.

Reset
REQ-024 On reset=1 at a clock edge: state=STABLE, stable_val=0, candidate=0, cnt=0, changed=0, change_count=0, synchronizer flops=0, irq=0.
REQ-025 Reset SHALL take priority over all events, including mid-SETTLING and COMMIT; an in-progress debounce SHALL be discarded.
REQ-026 After reset deassertion, non-zero switches SHALL be committed through the normal debounce path, setting changed.

Configuration
REQ-027 With macro SW_INPORT_IRQ_EN defined: irq SHALL be a registered output equal to changed, so it rises one cycle after COMMIT and falls the cycle after the clearing read.
REQ-028 Without SW_INPORT_IRQ_EN: irq SHALL be tied to 0 and no irq logic synthesized; all other behaviour is identical.

Verification
REQ-029 Reset, sw=0x00 held: in_port0=0, in_port1=0, irq=0 for 100 cycles.
REQ-030 sw 0x00->0xA5 held clean, DEBOUNCE_CYCLES=16: in_port0 becomes 0x000000A5 exactly 19 cycles after the edge, and in_port1 becomes 0x00000101.
REQ-031 sw toggles 0x00/0x01 every 5 cycles for 200 cycles, then returns to 0x00: no commit; in_port0 stays 0 and change_count stays 0.
REQ-032 rd_status pulse coincident with COMMIT: changed stays 1; a later lone rd_status clears it (in_port1 bit0=0) while change_count is retained.
REQ-033 256 clean commits: change_count wraps to 0x00 and changed=1; with SW_INPORT_IRQ_EN, irq=1 until rd_status, and irq=0 throughout without the macro.
REQ-034 reset asserted mid-SETTLING (cnt=8): all outputs are 0 the next cycle; the held sw is recommitted 19 cycles after reset release.
